// File: rtl/w450_mmio.sv
// MMIO responder beside the w450 data memory: byte-out FIFO, halt/exit code, status overlay on read port 2.
// Latency: a write is captured at the sampling edge; a pushed byte is on out_data/out_valid the cycle after.
// Backpressure: out_ready holds the FIFO head; a push into a full FIFO with no same-edge pop is dropped and flagged in overflow.
module w450_mmio #(
    parameter int             n         = 8,
    parameter int             DEPTH     = 4,
    parameter logic [n-1:0]   ADDR_CLR  = 8'hFC,
    parameter logic [n-1:0]   ADDR_STAT = 8'hFD,
    parameter logic [n-1:0]   ADDR_TX   = 8'hFE,
    parameter logic [n-1:0]   ADDR_HALT = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] mem_wr_data,
    input  logic [n-1:0] mem_wr_addr,
    input  logic         mem_wr_en,
    input  logic [n-1:0] mem_rd_addr2,
    input  logic [n-1:0] mem_rd_data2_in,
    output logic [n-1:0] mem_rd_data2_out,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         halted,
    output logic [n-1:0] halt_code,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [n-1:0]  fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    count4;
    logic [7:0]    stat_byte;

    logic wr_act;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic push_ok;
    logic push_drop;

    // Writes are only decoded while running; the memory itself still sees every write.
    assign wr_act    = mem_wr_en && !halted;
    assign push      = wr_act && (mem_wr_addr == ADDR_TX);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);
    assign push_drop = push && full && !pop;

    assign out_valid = !empty;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

    // Status reports count in a 4-bit field regardless of the FIFO depth.
    generate
        if (CW >= 4) begin : g_cnt_trunc
            assign count4 = count[3:0];
        end else begin : g_cnt_ext
            assign count4 = {{(4 - CW){1'b0}}, count};
        end
    endgenerate

    assign stat_byte        = {halted, overflow, full, empty, count4};
    assign mem_rd_data2_out = (mem_rd_addr2 == ADDR_STAT) ? n'(stat_byte) : mem_rd_data2_in;

    // FIFO storage needs no reset: out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky halt with its exit code; a zero write to the halt address is a no-op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted    <= 1'b0;
            halt_code <= '0;
        end else if (wr_act && (mem_wr_addr == ADDR_HALT) && (mem_wr_data != '0)) begin
            halted    <= 1'b1;
            halt_code <= mem_wr_data;
        end
    end

    // Sticky overflow, set by a dropped push and cleared only by software.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (wr_act && (mem_wr_addr == ADDR_CLR)) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_w450_mmio.sv
// Bench for w450_mmio: queue-based reference model checked every cycle, plus directed literal checks.
// Inputs change 2 time units after a rising edge; outputs are compared on the falling edge.
// Reset is also pulled mid-cycle to exercise the asynchronous clear.
module tb_w450_mmio;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_wr_addr;
    logic       mem_wr_en;
    logic [7:0] mem_rd_addr2;
    logic [7:0] mem_rd_data2_in;
    logic [7:0] mem_rd_data2_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;
    logic [7:0] halt_code;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    w450_mmio #(.n(8), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_en        (mem_wr_en),
        .mem_rd_addr2     (mem_rd_addr2),
        .mem_rd_data2_in  (mem_rd_data2_in),
        .mem_rd_data2_out (mem_rd_data2_out),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .halted           (halted),
        .halt_code        (halt_code),
        .overflow         (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, flags are plain bits.
    logic [7:0] q[$];
    logic       m_halted = 1'b0;
    logic [7:0] m_code   = 8'h00;
    logic       m_ovf    = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_halted = 1'b0;
            m_code   = 8'h00;
            m_ovf    = 1'b0;
        end else begin
            logic do_pop;
            logic do_push;
            do_pop  = (q.size() != 0) && out_ready;
            do_push = 1'b0;
            if (mem_wr_en && !m_halted) begin
                if (mem_wr_addr == 8'hFE) begin
                    if (q.size() < DEPTH || do_pop) do_push = 1'b1;
                    else m_ovf = 1'b1;
                end else if (mem_wr_addr == 8'hFF && mem_wr_data != 8'h00) begin
                    m_halted = 1'b1;
                    m_code   = mem_wr_data;
                end else if (mem_wr_addr == 8'hFC) begin
                    m_ovf = 1'b0;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(mem_wr_data);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int         sz;
        logic [7:0] e_data;
        logic [7:0] e_rd;
        sz     = q.size();
        e_data = (sz != 0) ? q[0] : 8'h00;
        e_rd   = (mem_rd_addr2 == 8'hFD)
                 ? {m_halted, m_ovf, (sz == DEPTH), (sz == 0), 4'(sz)}
                 : mem_rd_data2_in;
        chk("m_out_valid", {7'b0, out_valid}, {7'b0, (sz != 0)});
        chk("m_out_data",  out_data, e_data);
        chk("m_halted",    {7'b0, halted}, {7'b0, m_halted});
        chk("m_halt_code", halt_code, m_code);
        chk("m_overflow",  {7'b0, overflow}, {7'b0, m_ovf});
        chk("m_rd_data2",  mem_rd_data2_out, e_rd);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mem_wr_addr = a;
        mem_wr_data = d;
        mem_wr_en   = 1'b1;
        tick();
        mem_wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp4 [4];
        reset           = 1'b0;
        mem_wr_data     = 8'h00;
        mem_wr_addr     = 8'h00;
        mem_wr_en       = 1'b0;
        mem_rd_addr2    = 8'hFD;
        mem_rd_data2_in = 8'h5A;
        out_ready       = 1'b0;

        // Reset and idle
        #28;
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_data",  out_data, 8'h00);
        chk("rst_halted",    {7'b0, halted}, 8'h00);
        chk("rst_halt_code", halt_code, 8'h00);
        chk("rst_overflow",  {7'b0, overflow}, 8'h00);
        chk("rst_status",    mem_rd_data2_out, 8'h10);
        mem_rd_addr2 = 8'h10;
        #1;
        chk("passthrough", mem_rd_data2_out, 8'h5A);
        mem_rd_addr2 = 8'hFD;
        #3;
        reset = 1'b1;
        tick();

        // Single byte, held under backpressure, then popped
        wr(8'hFE, 8'h41);
        chk("single_valid", {7'b0, out_valid}, 8'h01);
        chk("single_data",  out_data, 8'h41);
        tick();
        chk("single_held",  out_data, 8'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_popped", {7'b0, out_valid}, 8'h00);

        // Fill past DEPTH: fifth byte dropped
        for (int i = 1; i <= 5; i++) wr(8'hFE, 8'(i));
        chk("fill_overflow", {7'b0, overflow}, 8'h01);
        chk("fill_status",   mem_rd_data2_out, 8'h64);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", out_data, 8'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty",  {7'b0, out_valid}, 8'h00);
        chk("drain_status", mem_rd_data2_out, 8'h50);
        wr(8'hFC, 8'h00);
        chk("clr_overflow", {7'b0, overflow}, 8'h00);
        chk("clr_status",   mem_rd_data2_out, 8'h10);
        wr(8'h20, 8'h99);
        chk("other_addr_status", mem_rd_data2_out, 8'h10);

        // Full with a simultaneous pop and push
        wr(8'hFE, 8'h11);
        wr(8'hFE, 8'h22);
        wr(8'hFE, 8'h33);
        wr(8'hFE, 8'h44);
        chk("full_status", mem_rd_data2_out, 8'h24);
        out_ready = 1'b1;
        wr(8'hFE, 8'hAA);
        chk("pushpop_status", mem_rd_data2_out, 8'h24);
        exp4 = '{8'h22, 8'h33, 8'h44, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_order", out_data, exp4[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("pushpop_empty", {7'b0, out_valid}, 8'h00);

        // Halt
        wr(8'hFF, 8'h00);
        chk("halt_zero", {7'b0, halted}, 8'h00);
        wr(8'hFE, 8'h31);
        wr(8'hFE, 8'h32);
        wr(8'hFF, 8'h01);
        chk("halt_set",    {7'b0, halted}, 8'h01);
        chk("halt_code",   halt_code, 8'h01);
        chk("halt_status", mem_rd_data2_out, 8'h82);
        wr(8'hFE, 8'h77);
        wr(8'hFF, 8'h05);
        chk("halt_ignore_status", mem_rd_data2_out, 8'h82);
        chk("halt_ignore_code",   halt_code, 8'h01);
        out_ready = 1'b1;
        chk("halt_drain0", out_data, 8'h31);
        tick();
        chk("halt_drain1", out_data, 8'h32);
        tick();
        chk("halt_drain_empty", {7'b0, out_valid}, 8'h00);
        out_ready = 1'b0;

        // Reset, then rebuild 3 bytes + halt and reset mid-cycle
        reset = 1'b0;
        #1;
        chk("rst2_halted", {7'b0, halted}, 8'h00);
        tick();
        reset = 1'b1;
        wr(8'hFE, 8'hC1);
        wr(8'hFE, 8'hC2);
        wr(8'hFE, 8'hC3);
        wr(8'hFF, 8'h09);
        chk("mid_pre_status", mem_rd_data2_out, 8'h83);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_out_valid", {7'b0, out_valid}, 8'h00);
        chk("mid_out_data",  out_data, 8'h00);
        chk("mid_halted",    {7'b0, halted}, 8'h00);
        chk("mid_halt_code", halt_code, 8'h00);
        chk("mid_status",    mem_rd_data2_out, 8'h10);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w450_mmio.md
Name: w450_mmio

Overview:
- Memory-mapped I/O responder for the w450 core.
- Sits beside the data memory on the same write bus and second read port.
- Captures core writes to reserved high addresses:
  - byte output, buffered in a FIFO and drained downstream by valid/ready;
  - halt/exit code.
- Overlays a status byte on read port 2.

Parameters:
- n, 8, data/address width
- DEPTH, 4, output FIFO depth (power of two, >=2)
- ADDR_CLR, 8'hFC, write clears overflow flag
- ADDR_STAT, 8'hFD, read returns status byte
- ADDR_TX, 8'hFE, write pushes data byte into FIFO
- ADDR_HALT, 8'hFF, write with nonzero data halts

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous active-low reset
- mem_wr_data  in  n  write data from core
- mem_wr_addr  in  n  write address from core
- mem_wr_en  in  1  write strobe from core
- mem_rd_addr2  in  n  read address 2 from core
- mem_rd_data2_in  in  n  read data 2 from memory
- mem_rd_data2_out  out  n  read data 2 to core (memory or status overlay)
- out_data  out  n  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts head
- halted  out  1  sticky halt flag
- halt_code  out  n  data written to ADDR_HALT
- overflow  out  1  sticky: a push was dropped while full

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty: count=0, rd_ptr=wr_ptr=0.
  - out_valid=0, out_data=0.
  - halted=0, halt_code=0, overflow=0.
  - Deassertion takes effect at the next rising edge.
- Write decode (sampled at rising clk when mem_wr_en=1 and halted=0):
  - addr==ADDR_TX: push mem_wr_data.
  - addr==ADDR_HALT and data!=0: halted<=1, halt_code<=data, same edge.
  - addr==ADDR_HALT and data==0: no effect.
  - addr==ADDR_CLR: overflow<=0.
  - Any other address: ignored. The memory still performs the write; this block does not gate mem_wr_en.
- Once halted=1, all writes are ignored until reset. The FIFO keeps draining after halt.
- Pop: rising edge with out_valid=1 and out_ready=1 advances rd_ptr.
- out_data:
  - Combinational from FIFO[rd_ptr] when out_valid=1; 0 when empty.
  - Stable while out_valid=1 and out_ready=0.
- out_valid = (count!=0).
- Push latency: a byte pushed at edge k gives out_valid=1 after edge k (visible cycle k+1).
- Full (count==DEPTH):
  - Push with no pop in the same edge is dropped; overflow<=1.
  - Push with simultaneous pop: both occur, count unchanged, no overflow.
- Empty with push: count->1. A pop is not possible the same edge because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Overflow set and ADDR_CLR write on the same edge cannot occur (single write port). Overflow set by a dropped push stays set until a later ADDR_CLR write.
- Read overlay (combinational):
  - mem_rd_addr2==ADDR_STAT: mem_rd_data2_out = {halted, overflow, full, empty, count[3:0] zero-extended/truncated to 4 bits}.
  - Otherwise: mem_rd_data2_out = mem_rd_data2_in.
- Halt and TX are separate addresses, so they never collide on one edge.

Test Plan:
- Reset then idle: hold reset low 30 time units -> all outputs 0. Read addr 8'hFD -> 8'h10 (empty=1).
- Single byte: write 8'h41 to 8'hFE with out_ready=0 -> out_valid=1, out_data=8'h41 from next cycle and held. Raise out_ready one cycle -> out_valid=0.
- Fill and overflow (DEPTH=4): write 8'h01..8'h05 to 8'hFE with out_ready=0:
  - 5th write dropped; overflow=1; status read = 8'h64.
  - Drain yields 01,02,03,04 in order.
  - Write to 8'hFC -> overflow=0.
- Full with simultaneous pop: FIFO full, out_ready=1, write 8'hAA same edge -> count stays 4, overflow=0. 8'hAA is emitted 4th after the current head.
- Halt: write 8'h00 to 8'hFF -> halted stays 0. Then write 8'h01 -> halted=1, halt_code=8'h01. Subsequent writes to 8'hFE are ignored, but already-queued bytes still drain.
- Reset mid-operation: FIFO holding 3 bytes and halted=1, pull reset low asynchronously between edges -> out_valid, halted, halt_code and count clear immediately without a clock edge.
